// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes and multiplier state encoding
//
// Purpose: shared constants for the execute-stage ALU and the sequential
//          multiplier that borrows it for its additions.
// Contents:
//   ALU_* opcodes   4-bit Operation codes understood by alu
//   mul_state_e     IDLE / BUSY / DONE states of alu_mul_seq
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b1100;
  localparam logic [3:0] ALU_SRL = 4'b1101;
  localparam logic [3:0] ALU_SLT = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational execute-stage ALU
//
// Purpose: single-cycle ALU; result is a pure function of the inputs.
// Ports:
//   srca       in  DATA_WIDTH     first operand
//   srcb       in  DATA_WIDTH     second operand (low bits are the shift amount)
//   operation  in  OPCODE_LENGTH  ALU_* opcode from alu_pkg
//   alu_result out DATA_WIDTH     result; zero for unknown opcodes
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    srca,
  input  logic [DATA_WIDTH-1:0]    srcb,
  input  logic [OPCODE_LENGTH-1:0] operation,
  output logic [DATA_WIDTH-1:0]    alu_result
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt;

  assign shamt = srcb[SHW-1:0];

  always_comb begin
    alu_result = '0;
    case (operation)
      OPCODE_LENGTH'(ALU_AND): alu_result = srca & srcb;
      OPCODE_LENGTH'(ALU_OR):  alu_result = srca | srcb;
      OPCODE_LENGTH'(ALU_XOR): alu_result = srca ^ srcb;
      OPCODE_LENGTH'(ALU_SUB): alu_result = srca - srcb;
      OPCODE_LENGTH'(ALU_ADD): alu_result = srca + srcb;
      OPCODE_LENGTH'(ALU_SLL): alu_result = srca << shamt;
      OPCODE_LENGTH'(ALU_SRL): alu_result = srca >> shamt;
      OPCODE_LENGTH'(ALU_SLT): alu_result = DATA_WIDTH'($signed(srca) < $signed(srcb));
      default:                 alu_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add multiplier that reuses the core ALU adder
//
// Purpose: accepts an operand pair, performs one ALU addition per cycle
//          (acc + (mult[0] ? mcand : 0)) and returns the low DATA_WIDTH bits
//          of the product. Signed and unsigned operands give the same bits.
// Optional build macro: MUL_EARLY_EXIT_EN - finish as soon as the remaining
//          multiplier bits are all zero instead of always running DATA_WIDTH
//          cycles; the product is the same either way.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_valid/ready     operand handshake (ready only in IDLE)
//   op_a, op_b            multiplicand, multiplier
//   res_valid/ready       result handshake (valid only in DONE)
//   res_data              product, low DATA_WIDTH bits, held in DONE
//   busy                  high in BUSY or DONE
//   alu_srca/srcb/op      drive to the shared ALU
//   alu_result            ALU output, combinational in the same cycle
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [DATA_WIDTH-1:0]    op_a,
  input  logic [DATA_WIDTH-1:0]    op_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_WIDTH-1:0]    res_data,
  output logic                     busy,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  mul_state_e            state;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mult;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_W-1:0]      cnt;

  logic [DATA_WIDTH-1:0] mult_next;
  logic                  finish;

  assign mult_next = mult >> 1;

`ifdef MUL_EARLY_EXIT_EN
  // Once no set multiplier bits remain, further adds would only add zero.
  assign finish = (cnt == CNT_LAST) || (mult_next == '0);
`else
  assign finish = (cnt == CNT_LAST);
`endif

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);

  // Outside BUSY the ALU is parked on AND of zeros so it toggles nothing.
  always_comb begin
    alu_op   = OPCODE_LENGTH'(ALU_AND);
    alu_srca = '0;
    alu_srcb = '0;
    if (state == BUSY) begin
      alu_op   = OPCODE_LENGTH'(ALU_ADD);
      alu_srca = acc;
      alu_srcb = mult[0] ? mcand : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mcand    <= '0;
      mult     <= '0;
      acc      <= '0;
      cnt      <= '0;
      res_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            mcand <= op_a;
            mult  <= op_b;
            acc   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Bits of mcand shifted past the MSB are dropped: product mod 2^W.
          acc   <= alu_result;
          mcand <= mcand << 1;
          mult  <= mult_next;
          cnt   <= cnt + CNT_W'(1);
          if (finish) begin
            res_data <= alu_result;
            state    <= DONE;
          end
        end
        DONE: begin
          // No same-cycle restart: start_ready only rises after IDLE is entered.
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
